issue_select_queue: RTL
=======================

# issue_select_queue

Age-ordered issue queue that sits directly upstream of the delayed-wakeup stage. It accepts dispatched micro-ops, holds them until their operand dependency is satisfied, and selects the oldest ready entry each cycle. For each selected entry it emits a one-cycle `issu_en` pulse with an 8-bit latency mask `wdy` for the delayed-wakeup stage. That stage's `valid` output returns as `wake` and releases dependent entries.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries (2..8).
- `TAG_W`, 4: width of the micro-op tag.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; **asynchronous, active-low**.
- `in_valid`  in  1  dispatch request.
- `in_ready`  out  1  queue can accept; equals `count < DEPTH`.
- `in_lat`  in  3  execution latency code L; latency is L+1 cycles (1..8).
- `in_dep`  in  1  1 = entry must wait for a `wake` pulse before issuing.
- `in_tag`  in  TAG_W  micro-op tag.
- `wake`  in  1  wakeup pulse from the delayed-wakeup stage (`valid`).
- `issu_en`  out  1  registered one-cycle issue pulse.
- `wdy`  out  8  registered latency mask: `~(8'hFF >> (L+1))`; 0 when `issu_en`=0.
- `issu_tag`  out  TAG_W  registered tag of the issued entry; 0 when `issu_en`=0.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Entry fields: `v`, `dep`, `lat[2:0]`, `tag`.
- Entries are kept compacted by age: index 0 holds the oldest entry.
- Ready condition: `v && !dep`.
- Select: the lowest-index ready entry; at most one issue per cycle.
- Issue:
  - The selected entry is removed.
  - Younger entries shift down by one.
  - Registered outputs load `issu_en`=1, `wdy`=mask(lat), `issu_tag`=tag.
- Dispatch:
  - Occurs when `in_valid && in_ready`.
  - The new entry is appended at index `count`, or `count-1` if an issue happens in the same cycle.
  - It is written with `dep=in_dep`.
- Wake:
  - When `wake`=1 at an edge, `dep` is cleared in every valid resident entry.
  - Wake does not clear `dep` of an entry dispatched at that same edge; that entry waits for the next `wake`.
  - Wake is not counted or stored: a wake with no dependent entries is dropped.
- Mask examples:
  - L=0 gives 8'b1000_0000.
  - L=4 gives 8'b1111_1000.
  - L=7 gives 8'hFF.
- Full: `in_ready`=0 when `count==DEPTH`, even if an issue occurs that cycle (no same-cycle replacement).
- Empty: no select, `issu_en`=0.
- Reset (asserted at any time, including mid-operation):
  - All `v`=0 and `count`=0.
  - `issu_en`=0, `wdy`=0, `issu_tag`=0.
  - `in_ready`=1.
  - In-flight contents are discarded.

## Timing
- Dispatch accepted at edge k: earliest `issu_en` is high for the cycle after edge k+1 (one-cycle select latency, no bypass).
- `wake` sampled at edge j: the released entry can issue with `issu_en` high after edge j+1.
- `issu_en` is never high for two consecutive cycles for the same tag.
- Back-to-back issues of different ready entries may occur on consecutive cycles.
- `count` updates at the edge: +1 for dispatch, −1 for issue, unchanged for both or neither.
- `in_ready` is combinational from registered `count` only; it has no dependence on `in_valid` or `wake`.

## Structure
- Shared package `issue_pkg`:
  - `LAT_W=3` and `WDY_W=8`.
  - Entry struct type `iq_entry_t`.
  - Function `lat_to_wdy(L)`.
- Sub-module `iq_age_select`:
  - Inputs: ready vector.
  - Outputs: one-hot grant and binary index of the lowest set bit, plus `any`.
  - Purely combinational.
- Top level holds the entry array, compaction/shift logic, count, and output registers.

## Test plan
- **Reset mid-operation.**
  - Stimulus: fill 3 entries with `in_dep`=1, pulse `rst`=0 for 10 ns.
  - Required response: `count`=0, `issu_en`/`wdy`/`issu_tag`=0, `in_ready`=1; no issue afterwards even when `wake` pulses.
- **Independent issue.**
  - Stimulus: dispatch tag 3, L=4, dep=0 at edge k.
  - Required response: `issu_en`=1, `wdy`=8'b1111_1000, `issu_tag`=3 for exactly one cycle after edge k+1; `count` returns to 0.
- **Dependency and wake.**
  - Stimulus: dispatch tag 1 (dep=1) then tag 2 (dep=0).
  - Required response: tag 2 issues first.
  - Follow-up: pulse `wake` at edge j.
  - Required response: tag 1 issues after edge j+1 with its own mask.
- **Age order.**
  - Stimulus: dispatch tags 5, 6, 7, all dep=0, on consecutive cycles.
  - Required response: issues in order 5, 6, 7 on consecutive cycles.
- **Full queue.**
  - Stimulus: DEPTH=4, four dep=1 dispatches.
  - Required response: `in_ready`=0 and a fifth `in_valid` is ignored.
  - Follow-up: `wake`.
  - Required response: four issues in dispatch order, then `in_ready`=1.
- **Simultaneous events.**
  - Stimulus: `wake` and a dep=1 dispatch (tag 9) at the same edge, with one resident dep=1 entry (tag 8).
  - Required response: tag 8 issues; tag 9 stays until the next `wake`.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types and helpers for the age-ordered issue queue.
package issue_pkg;

  localparam int unsigned LAT_W     = 3;
  localparam int unsigned WDY_W     = 8;
  // Storage width for tags inside an entry; the queue's TAG_W must not exceed it.
  localparam int unsigned TAG_MAX_W = 8;

  typedef struct packed {
    logic                 v;
    logic                 dep;
    logic [LAT_W-1:0]     lat;
    logic [TAG_MAX_W-1:0] tag;
  } iq_entry_t;

  // Latency code L (L+1 cycles) to a left-aligned mask with L+1 ones.
  function automatic logic [WDY_W-1:0] lat_to_wdy(input logic [LAT_W-1:0] l);
    logic [WDY_W-1:0] ones;
    ones = '1;
    return ~(ones >> ({1'b0, l} + 4'd1));
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Lowest-index priority picker: one-hot grant, binary index and any flag.
module iq_age_select #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  ready_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan upward; the first ready bit wins and blocks all higher ones.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ready_i[i] && !any_o) begin
        grant_o[i] = 1'b1;
        idx_o      = IW'(i);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_select_queue.sv
// Age-ordered issue queue: holds dispatched micro-ops until their dependency
// is released by wake, then issues the oldest ready one per cycle.
module issue_select_queue
  import issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LAT_W-1:0]       in_lat,
  input  logic                   in_dep,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic                   wake,
  output logic                   issu_en,
  output logic [WDY_W-1:0]       wdy,
  output logic [TAG_W-1:0]       issu_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = $clog2(DEPTH);

  iq_entry_t              entries_q [DEPTH];
  iq_entry_t              entries_d [DEPTH];
  logic      [CW-1:0]     count_q, count_d;
  logic                   issu_en_q, issu_en_d;
  logic      [WDY_W-1:0]  wdy_q, wdy_d;
  logic      [TAG_W-1:0]  issu_tag_q, issu_tag_d;

  logic      [DEPTH-1:0]  ready_vec;
  logic      [DEPTH-1:0]  sel_grant;
  logic      [IW-1:0]     sel_idx;
  logic                   sel_any;
  logic      [LAT_W-1:0]  sel_lat;
  logic      [TAG_W-1:0]  sel_tag;
  logic                   do_disp;
  logic      [CW-1:0]     app_pos;

  assign in_ready = (count_q < CW'(DEPTH));
  assign count    = count_q;
  assign issu_en  = issu_en_q;
  assign wdy      = wdy_q;
  assign issu_tag = issu_tag_q;

  // Entries eligible to issue this cycle.
  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries_q[i].v && !entries_q[i].dep;
    end
  end

  iq_age_select #(
    .N (DEPTH)
  ) u_select (
    .ready_i (ready_vec),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  // One-hot mux of the granted entry's latency and tag.
  always_comb begin
    sel_lat = '0;
    sel_tag = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_grant[i]) begin
        sel_lat = entries_q[i].lat;
        sel_tag = entries_q[i].tag[TAG_W-1:0];
      end
    end
  end

  // Next queue contents: remove+compact, then wake residents, then append.
  // Wake is applied before the append so a same-edge dispatch keeps its dep.
  always_comb begin
    entries_d = entries_q;
    do_disp   = in_valid && in_ready;
    app_pos   = count_q - CW'(sel_any);

    if (sel_any) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        if (i >= 32'(sel_idx)) begin
          entries_d[i] = entries_q[i+1];
        end
      end
      entries_d[DEPTH-1] = '0;
    end

    if (wake) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (entries_d[i].v) begin
          entries_d[i].dep = 1'b0;
        end
      end
    end

    if (do_disp) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == app_pos) begin
          entries_d[i].v   = 1'b1;
          entries_d[i].dep = in_dep;
          entries_d[i].lat = in_lat;
          entries_d[i].tag = TAG_MAX_W'(in_tag);
        end
      end
    end

    unique case ({do_disp, sel_any})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue output values loaded at the edge that removes the entry.
  always_comb begin
    issu_en_d  = sel_any;
    wdy_d      = sel_any ? lat_to_wdy(sel_lat) : '0;
    issu_tag_d = sel_any ? sel_tag : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q  <= '{default: '0};
      count_q    <= '0;
      issu_en_q  <= 1'b0;
      wdy_q      <= '0;
      issu_tag_q <= '0;
    end else begin
      entries_q  <= entries_d;
      count_q    <= count_d;
      issu_en_q  <= issu_en_d;
      wdy_q      <= wdy_d;
      issu_tag_q <= issu_tag_d;
    end
  end

endmodule
